pc_ctrl: RTL
============

# pc_ctrl

Program-counter and fetch sequencer for the core's IF stage. It owns the PC register and drives the instruction-memory request handshake. It applies redirects decided by the branch unit in EX, with branch-unit `pc_sel` encoding and EX operands as inputs, and flushes the younger pipeline stages. A one-entry skid buffer holds an instruction returned while IF/ID is stalled.

## Interface
- `XLEN`, 32: datapath and address width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `stall_i` in 1: IF/ID cannot accept an instruction this cycle (hazard unit).
- `ex_valid_i` in 1: the EX instruction is valid.
- `pc_sel_i` in 2: branch-unit output.
  - 00: sequential.
  - 01: PC-relative target (`ex_pc_i + imm_i`).
  - 10: register target (`(rs1_i + imm_i) & ~1`).
  - 11: reserved, treated as 00.
- `ex_pc_i` in XLEN: PC of the EX instruction.
- `imm_i` in XLEN: sign-extended immediate.
- `rs1_i` in XLEN: rs1 operand.
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out XLEN: fetch address; stable while `imem_req_o` is high and `imem_ready_i` is low.
- `imem_ready_i` in 1: request accepted and `imem_rdata_i` valid in the same cycle.
- `imem_rdata_i` in 32: fetched instruction.
- `if_valid_o` out 1: `if_instr_o`/`if_pc_o` valid for IF/ID this cycle.
- `if_instr_o` out 32: instruction to IF/ID.
- `if_pc_o` out XLEN: PC of `if_instr_o`.
- `flush_o` out 1: kill IF/ID and ID/EX contents at this edge; combinational.
- `misalign_o` out 1: one-cycle pulse when a redirect target has `[1:0] != 0`.
- `halted_o` out 1: controller is in HALT.

## Operation
- States:
  - BOOT: first cycle after reset, no request.
  - RUN: issue requests.
  - WAIT_MEM: a request is outstanding.
  - HELD: the skid buffer is full.
  - HALT.
- Redirect condition: `ex_valid_i & (pc_sel_i == 01 | pc_sel_i == 10) & ~halted_o`.
  - A redirect takes priority over `stall_i` and over sequential fetch.
  - `flush_o` equals the redirect condition.
- Redirect target arithmetic:
  - 01: `ex_pc_i + imm_i`, modulo 2^XLEN.
  - 10: `(rs1_i + imm_i) & ~1`, modulo 2^XLEN.
- Misaligned target (`target[1:0] != 0`): no PC update and no flush. `misalign_o` pulses the next cycle and the state goes to HALT. HALT is left only by `rst_i`.
- Per-state behaviour:
  - BOOT → RUN unconditionally.
  - RUN: `imem_req_o = ~stall_i`.
    - If ready: deliver, `pc += 4`, stay in RUN.
    - If not ready: go to WAIT_MEM.
  - WAIT_MEM: `imem_req_o` held high with the address unchanged.
    - On ready with `~stall_i`: deliver and go to RUN.
    - On ready with `stall_i`: capture into the skid buffer and go to HELD.
  - HELD: no request. When `~stall_i`, present the buffer (`if_valid_o = 1`) and go to RUN.
- Redirect interaction by state:
  - In RUN or HELD: the PC loads the target, the skid buffer is emptied, the state becomes RUN, and no delivery happens this cycle.
  - In WAIT_MEM: the target is latched into a pending register and a discard flag is set. The address stays stable. The returning instruction is dropped (`if_valid_o = 0`), then the PC loads the pending target and the state becomes RUN.
  - A second redirect while discard is pending overwrites the pending target.
- `if_valid_o` is never asserted in a cycle where `flush_o = 1`.
- PC wrap: `0xFFFF_FFFC + 4` wraps to `0` silently.

## Timing
- Reset values:
  - `imem_req_o = 0`, `imem_addr_o = RESET_PC`.
  - `if_valid_o = 0`, `if_instr_o = 0`, `if_pc_o = 0`.
  - `misalign_o = 0`, `halted_o = 0`, `flush_o = 0` (forced regardless of inputs).
- `rst_i` mid-request abandons the outstanding request. Memory must tolerate a request dropping on reset.
- First request: cycle 2 after `rst_i` falls (BOOT occupies cycle 1).
- Redirect sampled at edge N: `imem_addr_o = target` in cycle N+1 from RUN/HELD. From WAIT_MEM, it appears in the cycle after the discarded ready.
- Delivery is combinational from `imem_rdata_i` in RUN/WAIT_MEM and registered from the skid buffer in HELD.
- Throughput: one instruction per cycle with `imem_ready_i` tied high and no stalls.

## Structure
- Shared package `core_pkg`:
  - `PC_SEQ = 2'b00`, `PC_REL = 2'b01`, `PC_REG = 2'b10`, shared with the branch unit and decoder.
  - The state enum for this block.
- One sub-module, `pc_target`: combinational target adder plus the alignment check.
- The FSM, PC register, pending register and skid buffer live in `pc_ctrl`.

## Test plan
- Reset, then `imem_ready_i = 1` continuously → addresses 0x0, 0x4, 0x8, 0xC on consecutive cycles, `if_valid_o` high from cycle 2.
- At PC 0x10, `pc_sel_i = 01`, `ex_pc_i = 0x8`, `imm_i = 0x20` → `flush_o = 1` that cycle, next address 0x28, no delivery in the flush cycle.
- `pc_sel_i = 10`, `rs1_i = 0x101`, `imm_i = 0x3` → target 0x104. Then `rs1_i = 0x102`, `imm_i = 0` → `misalign_o` pulse, `halted_o = 1`, requests stop until `rst_i`.
- Ready held low 3 cycles at 0x20 with a redirect to 0x80 in the 2nd → address stays 0x20, returned word dropped, next request 0x80.
- `stall_i` high while in WAIT_MEM, ready arrives with 0x00A00093 → HELD, no request. On stall release: `if_valid_o = 1`, `if_instr_o = 0x00A00093`.
- `pc_sel_i = 11` with `ex_valid_i = 1` → no flush, sequential fetch. `rst_i` asserted mid-WAIT_MEM → all outputs at reset values next cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: branch-unit pc_sel encoding and the fetch sequencer states.
package core_pkg;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_REL = 2'b01;
   localparam logic [1:0] PC_REG = 2'b10;

   typedef enum logic [2:0] {
      PC_BOOT,
      PC_RUN,
      PC_WAIT_MEM,
      PC_HELD,
      PC_HALT
   } pc_state_e;

endpackage

// File: rtl/pc_target.sv
// Redirect target adder and word-alignment check for the fetch sequencer.
module pc_target
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      i_pc_sel,
   input  logic [XLEN-1:0] i_ex_pc,
   input  logic [XLEN-1:0] i_imm,
   input  logic [XLEN-1:0] i_rs1,
   output logic [XLEN-1:0] o_target,
   output logic            o_misalign
);

   logic [XLEN-1:0] w_rel_sum;
   logic [XLEN-1:0] w_reg_sum;

   assign w_rel_sum = i_ex_pc + i_imm;
   assign w_reg_sum = i_rs1 + i_imm;

   // Register-indirect targets drop bit 0; anything else uses the PC-relative sum.
   assign o_target   = (i_pc_sel == PC_REG) ? {w_reg_sum[XLEN-1:1], 1'b0} : w_rel_sum;
   assign o_misalign = |o_target[1:0];

endmodule

// File: rtl/pc_ctrl.sv
// IF-stage program counter, instruction-memory request sequencer and one-entry skid buffer.
module pc_ctrl
   import core_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_i,
   input  logic            ex_valid_i,
   input  logic [1:0]      pc_sel_i,
   input  logic [XLEN-1:0] ex_pc_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [XLEN-1:0] rs1_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ready_i,
   input  logic [31:0]     imem_rdata_i,
   output logic            if_valid_o,
   output logic [31:0]     if_instr_o,
   output logic [XLEN-1:0] if_pc_o,
   output logic            flush_o,
   output logic            misalign_o,
   output logic            halted_o
);

   pc_state_e       r_state, w_state_n;
   logic [XLEN-1:0] r_pc, w_pc_n;
   logic [XLEN-1:0] r_pend, w_pend_n;
   logic            r_disc, w_disc_n;
   logic [31:0]     r_skid_instr;
   logic [XLEN-1:0] r_skid_pc;
   logic            r_misal;

   logic [XLEN-1:0] w_tgt;
   logic            w_tgt_bad;
   logic            w_redir;
   logic            w_req;
   logic            w_deliver;
   logic            w_present;
   logic            w_skid_ld;

   pc_target #(.XLEN(XLEN)) u_target (
      .i_pc_sel   (pc_sel_i),
      .i_ex_pc    (ex_pc_i),
      .i_imm      (imm_i),
      .i_rs1      (rs1_i),
      .o_target   (w_tgt),
      .o_misalign (w_tgt_bad)
   );

   assign w_redir = ~rst_i & ex_valid_i & ((pc_sel_i == PC_REL) | (pc_sel_i == PC_REG))
                    & (r_state != PC_HALT);

   // Next-state / fetch decisions; a redirect overrides whatever the state would do.
   always_comb begin
      w_state_n = r_state;
      w_pc_n    = r_pc;
      w_pend_n  = r_pend;
      w_disc_n  = r_disc;
      w_skid_ld = 1'b0;
      w_req     = 1'b0;
      w_deliver = 1'b0;
      w_present = 1'b0;
      case (r_state)
         PC_BOOT: w_state_n = PC_RUN;
         PC_RUN: begin
            w_req = ~stall_i & ~w_redir;
            if (w_req) begin
               if (imem_ready_i) begin
                  w_deliver = 1'b1;
                  w_pc_n    = r_pc + XLEN'(4);
               end else begin
                  w_state_n = PC_WAIT_MEM;
               end
            end
         end
         PC_WAIT_MEM: begin
            // address must stay put until the memory answers
            w_req = 1'b1;
            if (imem_ready_i) begin
               w_state_n = PC_RUN;
               if (r_disc) begin
                  w_pc_n   = r_pend;
                  w_disc_n = 1'b0;
               end else if (!stall_i) begin
                  w_deliver = 1'b1;
                  w_pc_n    = r_pc + XLEN'(4);
               end else begin
                  w_skid_ld = 1'b1;
                  w_pc_n    = r_pc + XLEN'(4);
                  w_state_n = PC_HELD;
               end
            end
         end
         PC_HELD: begin
            if (!stall_i) begin
               w_present = 1'b1;
               w_state_n = PC_RUN;
            end
         end
         PC_HALT: ;
         default: w_state_n = PC_BOOT;
      endcase
      if (w_redir) begin
         w_deliver = 1'b0;
         w_present = 1'b0;
         w_skid_ld = 1'b0;
         if (w_tgt_bad) begin
            // faulting redirect: freeze the PC and stop fetching
            w_pc_n    = r_pc;
            w_disc_n  = 1'b0;
            w_state_n = PC_HALT;
         end else if ((r_state == PC_WAIT_MEM) && !imem_ready_i) begin
            // request in flight: remember the target, drop the word when it lands
            w_pc_n    = r_pc;
            w_pend_n  = w_tgt;
            w_disc_n  = 1'b1;
            w_state_n = PC_WAIT_MEM;
         end else begin
            w_pc_n    = w_tgt;
            w_disc_n  = 1'b0;
            w_state_n = PC_RUN;
         end
      end
   end

   // State, PC, pending target, skid buffer and misalign pulse registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= PC_BOOT;
         r_pc         <= RESET_PC;
         r_pend       <= '0;
         r_disc       <= 1'b0;
         r_skid_instr <= '0;
         r_skid_pc    <= '0;
         r_misal      <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_pc    <= w_pc_n;
         r_pend  <= w_pend_n;
         r_disc  <= w_disc_n;
         r_misal <= w_redir & w_tgt_bad;
         if (w_skid_ld) begin
            r_skid_instr <= imem_rdata_i;
            r_skid_pc    <= r_pc;
         end
      end
   end

   assign imem_req_o  = w_req & ~rst_i;
   assign imem_addr_o = r_pc;
   assign if_valid_o  = (w_deliver | w_present) & ~rst_i;
   assign if_instr_o  = !if_valid_o ? 32'h0 : (w_present ? r_skid_instr : imem_rdata_i);
   assign if_pc_o     = !if_valid_o ? '0 : (w_present ? r_skid_pc : r_pc);
   assign flush_o     = w_redir & ~w_tgt_bad;
   assign misalign_o  = r_misal;
   assign halted_o    = (r_state == PC_HALT);

endmodule
